// File: rtl/rf_pkg.sv
//==============================================================================
// Module      : rf_pkg
// Description : Shared sizes and types for the 32x32 register file and its
//               one-hot write-address decoder.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package rf_pkg;

    localparam int RF_ADDR_W   = 5;
    localparam int RF_DATA_W   = 32;
    localparam int RF_DEPTH    = 32;
    localparam int RF_ZERO_IDX = 0;

    typedef logic [RF_ADDR_W-1:0] rf_addr_t;
    typedef logic [RF_DATA_W-1:0] rf_data_t;

endpackage : rf_pkg

`default_nettype wire

// File: rtl/rf_wr_decode.sv
//==============================================================================
// Module      : rf_wr_decode
// Description : 5-to-32 one-hot write-enable decoder. The output bit that
//               addresses the hardwired-zero register is always held low, so
//               writes to it are dropped at the source.
// Ports       : i_addr - write address
//               i_en   - write strobe
//               o_we   - one-hot per-entry write enable (bit 0 forced low)
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module rf_wr_decode
    import rf_pkg::*;
#(
    parameter int ADDR_WIDTH = RF_ADDR_W
) (
    input  logic [ADDR_WIDTH-1:0]      i_addr,
    input  logic                       i_en,
    output logic [(2**ADDR_WIDTH)-1:0] o_we
);

    always_comb begin
        o_we = '0;
        if (i_en) begin
            o_we[i_addr] = 1'b1;
        end
        // The zero register has no write path.
        o_we[RF_ZERO_IDX] = 1'b0;
    end

endmodule : rf_wr_decode

`default_nettype wire

// File: rtl/register_file_32x32.sv
//==============================================================================
// Module      : register_file_32x32
// Description : 32-entry register file, one write port, two registered read
//               ports. Register 0 always reads zero.
// Ports       : CLK      - clock, rising edge
//               RST      - synchronous active-high reset
//               READ     - read strobe, captures both read ports
//               WRITE    - write strobe
//               ADDR_R1  - read port 1 address
//               ADDR_R2  - read port 2 address
//               ADDR_W   - write address
//               DATA_W   - write data
//               DATA_R1  - registered read data, port 1
//               DATA_R2  - registered read data, port 2
//               RD_VALID - high for one cycle after each READ edge
// Config      : RF_BYPASS_EN - when defined, a same-edge READ and WRITE to the
//               same nonzero address forwards DATA_W to that read port.
//               When undefined, the read returns the pre-write contents.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module register_file_32x32
    import rf_pkg::*;
#(
    parameter int DATA_WIDTH = RF_DATA_W,
    parameter int ADDR_WIDTH = RF_ADDR_W
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  READ,
    input  logic                  WRITE,
    input  logic [ADDR_WIDTH-1:0] ADDR_R1,
    input  logic [ADDR_WIDTH-1:0] ADDR_R2,
    input  logic [ADDR_WIDTH-1:0] ADDR_W,
    input  logic [DATA_WIDTH-1:0] DATA_W,
    output logic [DATA_WIDTH-1:0] DATA_R1,
    output logic [DATA_WIDTH-1:0] DATA_R2,
    output logic                  RD_VALID
);

    localparam int C_DEPTH = 2**ADDR_WIDTH;

    logic [C_DEPTH-1:0]    w_we;

    logic [DATA_WIDTH-1:0] regs_q [C_DEPTH];
    logic [DATA_WIDTH-1:0] regs_d [C_DEPTH];
    logic [DATA_WIDTH-1:0] rd1_q, rd1_d;
    logic [DATA_WIDTH-1:0] rd2_q, rd2_d;
    logic                  valid_q, valid_d;

    logic [DATA_WIDTH-1:0] w_rd1_arr;
    logic [DATA_WIDTH-1:0] w_rd2_arr;
    logic [DATA_WIDTH-1:0] w_rd1_sel;
    logic [DATA_WIDTH-1:0] w_rd2_sel;

    rf_wr_decode #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_wr_decode (
        .i_addr (ADDR_W),
        .i_en   (WRITE),
        .o_we   (w_we)
    );

    // Storage next-state: only the decoded entry takes DATA_W. Entry 0 never
    // has an enable, so it stays at its reset value of zero.
    always_comb begin
        for (int i = 0; i < C_DEPTH; i++) begin
            regs_d[i] = regs_q[i];
            if (w_we[i]) begin
                regs_d[i] = DATA_W;
            end
        end
    end

    // Array read muxes; address 0 is forced to zero so the result does not
    // depend on the storage contents of entry 0.
    always_comb begin
        w_rd1_arr = (ADDR_R1 == ADDR_WIDTH'(RF_ZERO_IDX)) ? '0 : regs_q[ADDR_R1];
        w_rd2_arr = (ADDR_R2 == ADDR_WIDTH'(RF_ZERO_IDX)) ? '0 : regs_q[ADDR_R2];
    end

`ifdef RF_BYPASS_EN
    // Write-through forwarding, decided per port. The write-address-zero case
    // is excluded so the zero register never shows written data.
    logic w_fwd1;
    logic w_fwd2;

    always_comb begin
        w_fwd1    = WRITE && (ADDR_W != ADDR_WIDTH'(RF_ZERO_IDX)) && (ADDR_R1 == ADDR_W);
        w_fwd2    = WRITE && (ADDR_W != ADDR_WIDTH'(RF_ZERO_IDX)) && (ADDR_R2 == ADDR_W);
        w_rd1_sel = w_fwd1 ? DATA_W : w_rd1_arr;
        w_rd2_sel = w_fwd2 ? DATA_W : w_rd2_arr;
    end
`else
    // Without forwarding a same-edge read sees the pre-write contents.
    always_comb begin
        w_rd1_sel = w_rd1_arr;
        w_rd2_sel = w_rd2_arr;
    end
`endif

    // Read registers hold their value when READ is low; RD_VALID simply
    // follows READ one edge later.
    always_comb begin
        rd1_d   = rd1_q;
        rd2_d   = rd2_q;
        valid_d = READ;
        if (READ) begin
            rd1_d = w_rd1_sel;
            rd2_d = w_rd2_sel;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < C_DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            rd1_q   <= '0;
            rd2_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            for (int i = 0; i < C_DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            valid_q <= valid_d;
        end
    end

    assign DATA_R1  = rd1_q;
    assign DATA_R2  = rd2_q;
    assign RD_VALID = valid_q;

endmodule : register_file_32x32

`default_nettype wire

// File: doc/register_file_32x32.md
# register_file_32x32

Thirty-two-entry, 32-bit register file that consumes the one-hot write select produced by the 5-to-32 address decoder stage. It provides one write port and two registered read ports. It sits between instruction decode (register addresses) and the ALU operand/writeback path. Register 0 is hardwired to zero.

## Interface
Parameters:
- DATA_WIDTH, 32, register width in bits
- ADDR_WIDTH, 5, register address width; depth is 2**ADDR_WIDTH = 32 (fixed, matches the 5-to-32 decode)

Ports:
- CLK  input  1  clock; all state updates on the rising edge
- RST  input  1  reset; one clock, synchronous, active-high
- READ  input  1  read strobe; captures both read ports this edge
- WRITE  input  1  write strobe; commits DATA_W this edge
- ADDR_R1  input  5  read port 1 address
- ADDR_R2  input  5  read port 2 address
- ADDR_W  input  5  write address, fed to the internal one-hot decode
- DATA_W  input  32  write data
- DATA_R1  output  32  registered read data, port 1
- DATA_R2  output  32  registered read data, port 2
- RD_VALID  output  1  one-cycle pulse: DATA_R1/DATA_R2 updated by the previous edge

## Operation
- Storage: 32 × DATA_WIDTH flops. Write enable per entry = one-hot(ADDR_W) & WRITE. Bit 0 of the one-hot is masked.
- Write: WRITE=1 at an edge with ADDR_W≠0 → reg[ADDR_W] ← DATA_W. With ADDR_W=0 the write is silently dropped, and reg[0] reads 0 always.
- Read: READ=1 at an edge → DATA_R1 ← reg[ADDR_R1], DATA_R2 ← reg[ADDR_R2], RD_VALID ← 1.
- READ=0 at an edge → DATA_R1/DATA_R2 hold their previous values, and RD_VALID ← 0.
- Both ports may address the same register, and each receives the same value.
- Simultaneous READ and WRITE to the same nonzero address: resolved by RF_BYPASS_EN (see Configuration).
- Simultaneous READ and WRITE to different addresses: independent, with no interaction.
- Reset: RST=1 at an edge clears all 32 registers, DATA_R1=0, DATA_R2=0 and RD_VALID=0. RST overrides READ and WRITE on the same edge, including mid-stream. The first READ after RST deasserts returns 0 for every address.
- No X propagation: all outputs are defined from the first reset onward.

## Timing
- Write latency: 1 edge. The value is visible to a READ on the next edge, or the same edge with bypass.
- Read latency: 1 edge. Address and READ are sampled at edge N, and DATA_Rx and RD_VALID are valid after edge N.
- Back-to-back READ every cycle is supported. RD_VALID stays high while READ stays high.
- There is no stall and no backpressure, so READ and WRITE are accepted every cycle.
- Reset values: DATA_R1=0, DATA_R2=0, RD_VALID=0, all reg[i]=0.

## Configuration
- RF_BYPASS_EN defined: on a same-edge READ and WRITE where ADDR_Rx==ADDR_W≠0, DATA_Rx receives DATA_W (write-through forwarding). This applies per port independently.
- RF_BYPASS_EN undefined: the same case returns the pre-write register contents, and the new value is visible on the following READ.
- ADDR_W=0 is never forwarded in either build.

## Structure
- Shared package rf_pkg holds the following:
  - RF_ADDR_W=5, RF_DATA_W=32, RF_DEPTH=32, RF_ZERO_IDX=0
  - typedef rf_addr_t (5-bit)
  - typedef rf_data_t (32-bit)
- One sub-module, rf_wr_decode: 5-bit address plus enable in, 32-bit one-hot write-enable out, with bit 0 forced low.
- Read muxes and forwarding compare stay in the top module.

## Test plan
- Reset → after the RST edge, READ with ADDR_R1=5 and ADDR_R2=31 → DATA_R1=0, DATA_R2=0 and RD_VALID=1 one cycle later.
- Write 0xDEADBEEF to r7, then READ with ADDR_R1=7 and ADDR_R2=0 the next cycle → DATA_R1=0xDEADBEEF and DATA_R2=0.
- WRITE 0x12345678 to r0, then READ r0 on both ports → both ports read 0.
- Fill r1..r31 with value i×0x01010101, then sweep READ over all pairs (i, 31−i) → each port returns its address's pattern, and RD_VALID stays high for the whole sweep.
- r9 holds 0xA; same edge WRITE r9=0xB and READ ADDR_R1=9 → DATA_R1=0xB with RF_BYPASS_EN, or 0xA without it. The next READ returns 0xB in both builds.
- Mid-stream: hold READ=1 with r3=0x55, then assert RST together with WRITE r3=0x77 → outputs go to 0 and RD_VALID goes to 0. The next READ of r3 returns 0.
